// File: rtl/taxi_stats_pkg.sv
// Shared types and helpers for the statistics collector.
package taxi_stats_pkg;

  typedef enum logic [0:0] {STATE_IDLE, STATE_SCAN} stats_collect_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/taxi_stats_collect_prio.sv
// Lowest-index priority encoder over the per-channel urgent bits.
module taxi_stats_collect_prio #(
  parameter int CNT   = 8,
  parameter int IDX_W = 3
) (
  input  logic [CNT-1:0]   req_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = CNT - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/taxi_stats_collect.sv
// Per-channel event accumulators drained as {ID, count} records on an AXI4-Stream source.
// Optional macro TAXI_STATS_COLLECT_SAT_EN: saturating accumulators with a sticky flag reported in tuser.
module taxi_stats_collect
  import taxi_stats_pkg::*;
#(
  parameter int CNT           = 8,
  parameter int INC_W         = 8,
  parameter int ACC_W         = 16,
  parameter int ID_W          = 10,
  parameter int ID_BASE       = 0,
  parameter int UPDATE_PERIOD = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT*INC_W-1:0] stat_inc,
  input  logic                 stat_flush,
  output logic [ACC_W-1:0]     m_axis_stat_tdata,
  output logic [ID_W-1:0]      m_axis_stat_tid,
  output logic                 m_axis_stat_tuser,
  output logic                 m_axis_stat_tvalid,
  input  logic                 m_axis_stat_tready,
  output logic                 busy,
  output stats_collect_state_t dbg_state_o
);

  localparam int PTR_W = ptr_w(CNT);
  localparam int TMR_W = ptr_w(UPDATE_PERIOD);

  stats_collect_state_t state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             pending_q, pending_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [ACC_W-1:0] acc_q [CNT];
  logic [ACC_W-1:0] acc_d [CNT];
  logic             tvalid_q;
  logic [ACC_W-1:0] tdata_q;
  logic [ID_W-1:0]  tid_q;

  logic [CNT-1:0]   urgent;
  logic             urg_vld, urg_cap, scan_cap, scan_adv;
  logic [PTR_W-1:0] urg_idx, cap_idx;
  logic             slot_free, cap_en, tmr_wrap, sweep_req;

  always_comb begin
    for (int k = 0; k < CNT; k++) urgent[k] = acc_q[k][ACC_W-1];
  end

  taxi_stats_collect_prio #(.CNT(CNT), .IDX_W(PTR_W)) u_prio (
    .req_i   (urgent),
    .valid_o (urg_vld),
    .idx_o   (urg_idx)
  );

  // Record slot handshake: a record transfers on a cycle with tvalid && tready;
  // payload is held while tvalid is high and tready low, and tvalid never drops without a transfer.
  assign slot_free = !tvalid_q || m_axis_stat_tready;
  assign urg_cap   = slot_free && urg_vld;
  assign tmr_wrap  = (tmr_q == TMR_W'(UPDATE_PERIOD - 1));
  assign sweep_req = tmr_wrap || stat_flush;
  assign tmr_d     = tmr_wrap ? '0 : tmr_q + TMR_W'(1);

  // Sweep decision at the pointer; an urgent capture steals the slot and freezes the pointer.
  always_comb begin
    scan_adv = 1'b0;
    scan_cap = 1'b0;
    if (state_q == STATE_SCAN) begin
      if (acc_q[ptr_q] == '0) begin
        scan_adv = 1'b1;
      end else if (slot_free && !urg_cap) begin
        scan_adv = 1'b1;
        scan_cap = 1'b1;
      end
    end
  end

  assign cap_en  = urg_cap || scan_cap;
  assign cap_idx = urg_cap ? urg_idx : ptr_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    case (state_q)
      STATE_IDLE: begin
        if (sweep_req) begin
          state_d   = STATE_SCAN;
          ptr_d     = '0;
          pending_d = 1'b0;
        end
      end
      STATE_SCAN: begin
        pending_d = pending_q || sweep_req;
        if (scan_adv) begin
          if (ptr_q == PTR_W'(CNT - 1)) begin
            if (pending_q || sweep_req) begin
              ptr_d     = '0;
              pending_d = 1'b0;
            end else begin
              state_d = STATE_IDLE;
            end
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == STATE_SCAN) || tvalid_q || pending_q;
    dbg_state_o = state_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= STATE_IDLE;
      ptr_q     <= '0;
      pending_q <= 1'b0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      tmr_q     <= tmr_d;
    end
  end

`ifdef TAXI_STATS_COLLECT_SAT_EN
  logic [CNT-1:0] sat_q, sat_d;
  logic           tuser_q;

  // A captured channel restarts from this cycle's increment, so nothing is lost.
  always_comb begin
    for (int k = 0; k < CNT; k++) begin
      logic [ACC_W-1:0] inc_k;
      logic [ACC_W:0]   sum_k;
      logic             hit_k;
      inc_k    = ACC_W'(stat_inc[k*INC_W +: INC_W]);
      sum_k    = {1'b0, acc_q[k]} + {1'b0, inc_k};
      hit_k    = cap_en && (cap_idx == PTR_W'(k));
      acc_d[k] = hit_k ? inc_k : (sum_k[ACC_W] ? '1 : sum_k[ACC_W-1:0]);
      sat_d[k] = hit_k ? 1'b0 : (sat_q[k] || sum_k[ACC_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q   <= '0;
      tuser_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      if (cap_en) tuser_q <= sat_q[cap_idx];
    end
  end

  assign m_axis_stat_tuser = tuser_q;
`else
  always_comb begin
    for (int k = 0; k < CNT; k++) begin
      logic [ACC_W-1:0] inc_k;
      logic             hit_k;
      inc_k    = ACC_W'(stat_inc[k*INC_W +: INC_W]);
      hit_k    = cap_en && (cap_idx == PTR_W'(k));
      acc_d[k] = hit_k ? inc_k : acc_q[k] + inc_k;
    end
  end

  assign m_axis_stat_tuser = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CNT; k++) acc_q[k] <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tid_q    <= '0;
    end else begin
      for (int k = 0; k < CNT; k++) acc_q[k] <= acc_d[k];
      if (cap_en) begin
        tvalid_q <= 1'b1;
        tdata_q  <= acc_q[cap_idx];
        tid_q    <= ID_W'(ID_BASE) + ID_W'(cap_idx);
      end else if (m_axis_stat_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_stat_tvalid = tvalid_q;
  assign m_axis_stat_tdata  = tdata_q;
  assign m_axis_stat_tid    = tid_q;

endmodule

// File: tb/tb_taxi_stats_collect.sv
// Directed bench for taxi_stats_collect: vector table of single events plus multi-cycle sequences.
module tb_taxi_stats_collect;
  import taxi_stats_pkg::*;

  localparam int CNT     = 8;
  localparam int INC_W   = 8;
  localparam int ACC_W   = 8;
  localparam int ID_W    = 10;
  localparam int ID_BASE = 16;
  localparam int PERIOD  = 64;
  localparam int REC_W   = ID_W + ACC_W + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [CNT*INC_W-1:0] stat_inc;
  logic                 stat_flush;
  logic [ACC_W-1:0]     tdata;
  logic [ID_W-1:0]      tid;
  logic                 tuser, tvalid, tready, busy;
  stats_collect_state_t dbg_state;

  taxi_stats_collect #(
    .CNT(CNT), .INC_W(INC_W), .ACC_W(ACC_W), .ID_W(ID_W),
    .ID_BASE(ID_BASE), .UPDATE_PERIOD(PERIOD)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stat_inc           (stat_inc),
    .stat_flush         (stat_flush),
    .m_axis_stat_tdata  (tdata),
    .m_axis_stat_tid    (tid),
    .m_axis_stat_tuser  (tuser),
    .m_axis_stat_tvalid (tvalid),
    .m_axis_stat_tready (tready),
    .busy               (busy),
    .dbg_state_o        (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] got_q[$];

  // accepted records, sampled on the falling edge ahead of the transfer edge
  always @(negedge clk) begin
    if (rst_n && tvalid && tready) got_q.push_back({tid, tdata, tuser});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input int ch, input logic [INC_W-1:0] v);
    stat_inc = '0;
    stat_inc[ch*INC_W +: INC_W] = v;
  endtask

  task automatic pulse_flush();
    stat_flush = 1'b1;
    step();
    stat_flush = 1'b0;
  endtask

  task automatic wait_busy_low(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_rec(input string name, input logic [REC_W-1:0] r, input logic [REC_W-1:0] e);
    check({name, "_tid"},   32'(r[REC_W-1 -: ID_W]), 32'(e[REC_W-1 -: ID_W]));
    check({name, "_tdata"}, 32'(r[ACC_W:1]),         32'(e[ACC_W:1]));
    check({name, "_tuser"}, 32'(r[0]),               32'(e[0]));
  endtask

  typedef struct {
    int               chan;
    logic [INC_W-1:0] inc;
    logic [ID_W-1:0]  exp_tid;
    logic [ACC_W-1:0] exp_tdata;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [REC_W-1:0] r;
    logic [REC_W-1:0] held_rec;
    logic             held;
    int               stable_err, s0, s1, s7, other, zero;

    tbl[0] = '{3, 8'h05, 10'd19, 8'h05};
    tbl[1] = '{0, 8'h01, 10'd16, 8'h01};
    tbl[2] = '{7, 8'h7F, 10'd23, 8'h7F};
    tbl[3] = '{5, 8'h40, 10'd21, 8'h40};

    rst_n = 1'b0; stat_inc = '0; stat_flush = 1'b0; tready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata",  32'(tdata), 32'd0);
    check("rst_tid",    32'(tid), 32'd0);
    check("rst_tuser",  {31'd0, tuser}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_state",  32'(dbg_state), 32'(STATE_IDLE));
    step();
    rst_n = 1'b1;
    step();

    // single-event table
    for (int i = 0; i < 4; i++) begin
      wait_busy_low("pre_idle", 40);
      step();
      got_q.delete();
      tready = 1'b1;
      set_inc(tbl[i].chan, tbl[i].inc);
      step();
      stat_inc = '0;
      pulse_flush();
      exp_q.push_back({tbl[i].exp_tid, tbl[i].exp_tdata, 1'b0});
      repeat (20) step();
      check("single_count", got_q.size(), 1);
      if (got_q.size() > 0) check_rec("single", got_q.pop_front(), exp_q.pop_front());
      else exp_q.delete();
      wait_busy_low("single_busy", 20);
    end

    // urgent drain without flush: visible two edges after the increment edge
    step();
    got_q.delete();
    tready = 1'b1;
    set_inc(2, 8'h90);
    step();
    stat_inc = '0;
    @(negedge clk);
    @(negedge clk);
    check("urgent_tvalid", {31'd0, tvalid}, 32'd1);
    check_rec("urgent", {tid, tdata, tuser}, {10'd18, 8'h90, 1'b0});
    repeat (5) step();
    check("urgent_count", got_q.size(), 1);

    // periodic sweeps only
    wait_busy_low("per_idle", 40);
    step();
    got_q.delete();
    tready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      stat_inc = '0;
      stat_inc[0*INC_W +: INC_W] = 8'd1;
      stat_inc[7*INC_W +: INC_W] = 8'd1;
      step();
    end
    stat_inc = '0;
    repeat (140) step();
    s0 = 0; s7 = 0; other = 0; zero = 0;
    foreach (got_q[j]) begin
      r = got_q[j];
      if (r[ACC_W:1] == '0) zero++;
      if (r[REC_W-1 -: ID_W] == 10'd16) s0 += int'(r[ACC_W:1]);
      else if (r[REC_W-1 -: ID_W] == 10'd23) s7 += int'(r[ACC_W:1]);
      else other++;
    end
    check("per_sum_ch0", s0, 100);
    check("per_sum_ch7", s7, 100);
    check("per_other", other, 0);
    check("per_zero", zero, 0);
    check("per_multi", {31'd0, got_q.size() >= 2}, 32'd1);

    // backpressure with concurrent increments and a flush mid-stall
    wait_busy_low("bp_idle", 40);
    step();
    got_q.delete();
    tready = 1'b0; held = 1'b0; stable_err = 0; held_rec = '0;
    for (int c = 0; c < 50; c++) begin
      set_inc(1, 8'd1);
      stat_flush = (c == 10);
      @(negedge clk);
      if (tvalid) begin
        if (held && {tid, tdata, tuser} != held_rec) stable_err++;
        held = 1'b1;
        held_rec = {tid, tdata, tuser};
      end
      step();
    end
    stat_inc = '0;
    stat_flush = 1'b0;
    check("bp_held", {31'd0, held}, 32'd1);
    check("bp_stable", stable_err, 0);
    check("bp_no_xfer", got_q.size(), 0);
    tready = 1'b1;
    pulse_flush();
    repeat (40) step();
    s1 = 0; other = 0; zero = 0;
    foreach (got_q[j]) begin
      r = got_q[j];
      if (r[ACC_W:1] == '0) zero++;
      if (r[REC_W-1 -: ID_W] == 10'd17) s1 += int'(r[ACC_W:1]);
      else other++;
    end
    check("bp_sum_ch1", s1, 50);
    check("bp_other", other, 0);
    check("bp_zero", zero, 0);

    // saturation versus wrap on channel 0
    wait_busy_low("sat_idle", 40);
    step();
    got_q.delete();
    tready = 1'b0;
    set_inc(0, 8'hFF);
    repeat (4) step();
    stat_inc = '0;
    repeat (3) step();
    @(negedge clk);
    check("sat_first_valid", {31'd0, tvalid}, 32'd1);
    check_rec("sat_first_held", {tid, tdata, tuser}, {10'd16, 8'hFF, 1'b0});
    step();
    tready = 1'b1;
    repeat (20) step();
    check("sat_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check_rec("sat_rec0", got_q.pop_front(), {10'd16, 8'hFF, 1'b0});
`ifdef TAXI_STATS_COLLECT_SAT_EN
      check_rec("sat_rec1", got_q.pop_front(), {10'd16, 8'hFF, 1'b1});
`else
      check_rec("sat_rec1", got_q.pop_front(), {10'd16, 8'hFD, 1'b0});
`endif
    end

    // asynchronous reset with a record stalled in the slot
    wait_busy_low("ar_idle", 40);
    step();
    got_q.delete();
    tready = 1'b0;
    set_inc(4, 8'd9);
    step();
    stat_inc = '0;
    pulse_flush();
    for (int n = 0; n < 20 && !tvalid; n++) @(negedge clk);
    check("ar_valid_before", {31'd0, tvalid}, 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("ar_tvalid_drop", {31'd0, tvalid}, 32'd0);
    check("ar_busy_drop", {31'd0, busy}, 32'd0);
    check("ar_tdata_clr", 32'(tdata), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    tready = 1'b1;
    repeat (80) step();
    check("ar_no_stale", got_q.size(), 0);
    set_inc(6, 8'd3);
    step();
    stat_inc = '0;
    pulse_flush();
    repeat (20) step();
    check("ar_post_count", got_q.size(), 1);
    if (got_q.size() > 0) check_rec("ar_post", got_q.pop_front(), {10'd22, 8'h03, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
